// File: rtl/life_pkg.sv
// Shared types for the Game of Life generation sequencer: board geometry,
// the packed board type and the sequencer state encoding.
package life_pkg;

    localparam int BOARD_N    = 16;
    localparam int BOARD_BITS = BOARD_N * BOARD_N;

    // Row-major board: [row][col]
    typedef logic [BOARD_N-1:0][BOARD_N-1:0] board_t;

    // Encoding is visible on state_o, so the values are fixed
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_STILL  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/life_edge_det.sv
// Single-bit rising-edge detector. The history register clears on reset, so
// a request held through reset produces exactly one event after release.
module life_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    output logic evt_o
);

    logic req_q;

    // Remember last cycle's request level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) req_q <= 1'b0;
        else         req_q <= req_i;
    end

    assign evt_o = req_i & ~req_q;

endmodule

// File: rtl/life_sequencer.sv
// Generation controller for the 16x16 Game of Life board. Converts run /
// step / load requests into single-cycle load_en and gen_en strobes for a
// full-rate gameboard, paces free-running evolution with a tick counter and
// counts generations (saturating).
// Optional still-life halt: define LIFE_STILL_DETECT_EN to add the board
// snapshot and comparator so SETTLE can park the sequencer in STILL.
module life_sequencer
    import life_pkg::*;
#(
    parameter int PERIOD = 25000000,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step_req,
    input  logic                  load_req,
    input  logic [BOARD_BITS-1:0] board_in,
    output logic                  load_en,
    output logic                  gen_en,
    output logic [CNT_W-1:0]      gen_count,
    output logic                  halted,
    output logic [2:0]            state_o
);

    localparam int TICK_W = $clog2(PERIOD);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD - 1);

    seq_state_t        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              step_evt, load_evt;
    logic              still_hit;

    life_edge_det u_step_edge (
        .clk_i  (clk),
        .rst_ni (reset),
        .req_i  (step_req),
        .evt_o  (step_evt)
    );

    life_edge_det u_load_edge (
        .clk_i  (clk),
        .rst_ni (reset),
        .req_i  (load_req),
        .evt_o  (load_evt)
    );

`ifdef LIFE_STILL_DETECT_EN
    board_t snap_q;

    // Capture the pre-step board while gen_en is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  snap_q <= '0;
        else if (state_q == ST_STEP) snap_q <= board_t'(board_in);
    end

    // In SETTLE board_in already holds the post-step generation
    assign still_hit = (board_t'(board_in) == snap_q);
    assign halted    = (state_q == ST_STILL);
`else
    logic unused_board;

    assign unused_board = ^board_in;
    assign still_hit    = 1'b0;
    assign halted       = 1'b0;
`endif

    // Next-state, tick pacing and generation counter update
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                if (load_evt)      state_d = ST_LOAD;
                else if (step_evt) state_d = ST_STEP;
                else if (run)      state_d = ST_RUN;
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                // Dropping run wins over an expiring tick; step is ignored here
                if (load_evt) begin
                    tick_d  = '0;
                    state_d = ST_LOAD;
                end else if (!run) begin
                    tick_d  = '0;
                    state_d = ST_IDLE;
                end else if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    state_d = ST_STEP;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_STEP: begin
                cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (load_evt)       state_d = ST_LOAD;
                else if (still_hit) state_d = ST_STILL;
                else if (run)       state_d = ST_RUN;
                else                state_d = ST_IDLE;
            end
            ST_STILL: begin
                if (load_evt) state_d = ST_LOAD;
            end
            default: begin
                tick_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, tick and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore outputs: strobes last exactly the one cycle spent in their state
    assign load_en   = (state_q == ST_LOAD);
    assign gen_en    = (state_q == ST_STEP);
    assign gen_count = cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Self-checking bench for life_sequencer (PERIOD=4, CNT_W=4). Expectations
// come from the timing rules: first RUN pulse PERIOD+1 cycles after run
// rises, then one every PERIOD+2 cycles, saturating generation count.
// Build with LIFE_STILL_DETECT_EN defined to check the still-life halt.
module tb_life_sequencer;

    localparam int PERIOD = 4;
    localparam int CNT_W  = 4;
    localparam int SAT    = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             run = 1'b0;
    logic             step_req = 1'b0;
    logic             load_req = 1'b0;
    logic [255:0]     pat = '0;
    logic             toggle_en = 1'b0;
    logic [255:0]     board_in;
    logic             load_en, gen_en, halted;
    logic [CNT_W-1:0] gen_count;
    logic [2:0]       state_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gen_total = 0;
    int load_total = 0;
    int gen_times [0:1023];
    int exp_count = 0;

    life_sequencer #(.PERIOD(PERIOD), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step_req  (step_req),
        .load_req  (load_req),
        .board_in  (board_in),
        .load_en   (load_en),
        .gen_en    (gen_en),
        .gen_count (gen_count),
        .halted    (halted),
        .state_o   (state_o)
    );

    // Toggling board differs in every pair of adjacent cycles
    assign board_in = (toggle_en && cyc[0]) ? ~pat : pat;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (gen_en === 1'b1) begin
            gen_times[gen_total % 1024] <= cyc;
            gen_total <= gen_total + 1;
        end
        if (load_en === 1'b1) load_total <= load_total + 1;
    end

    function automatic int sat_add(input int a, input int b);
        return (a + b > SAT) ? SAT : a + b;
    endfunction

    // Pulses produced while run is sampled high for n edges from IDLE
    function automatic int run_pulses(input int n);
        if (n < PERIOD + 1) return 0;
        return (n - (PERIOD + 1)) / (PERIOD + 2) + 1;
    endfunction

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rand_pat();
        for (int i = 0; i < 8; i++) pat[i*32 +: 32] = $urandom();
    endtask

    task automatic test_reset();
        checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL reset_load_en got %b exp 0", load_en); end
        checks++; if (gen_en !== 1'b0) begin errors++; $display("FAIL reset_gen_en got %b exp 0", gen_en); end
        checks++; if (gen_count !== 4'd0) begin errors++; $display("FAIL reset_gen_count got %0d exp 0", gen_count); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
    endtask

    task automatic test_load();
        int l0, g0;
        l0 = load_total; g0 = gen_total;
        load_req = 1'b1; cyc_wait(3); load_req = 1'b0; cyc_wait(3);
        exp_count = 0;
        checks++; if (load_total - l0 !== 1) begin errors++; $display("FAIL load_pulses got %0d exp 1", load_total - l0); end
        checks++; if (gen_total - g0 !== 0) begin errors++; $display("FAIL load_no_gen got %0d exp 0", gen_total - g0); end
        checks++; if (gen_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL load_count got %0d exp %0d", gen_count, exp_count); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL load_state got %0d exp 0", state_o); end
    endtask

    task automatic test_step();
        int g0, c0;
        rand_pat(); toggle_en = 1'b1;
        g0 = gen_total; c0 = cyc;
        step_req = 1'b1; cyc_wait(5); step_req = 1'b0; cyc_wait(3);
        exp_count = sat_add(exp_count, 1);
        checks++; if (gen_total - g0 !== 1) begin errors++; $display("FAIL step_pulses got %0d exp 1", gen_total - g0); end
        checks++; if (gen_times[g0 % 1024] - c0 !== 1) begin errors++; $display("FAIL step_latency got %0d exp 1", gen_times[g0 % 1024] - c0); end
        checks++; if (gen_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL step_count got %0d exp %0d", gen_count, exp_count); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL step_state got %0d exp 0", state_o); end
    endtask

    task automatic test_free_run(input int n);
        int g0, g1, c0, exp_p;
        rand_pat(); toggle_en = 1'b1;
        g0 = gen_total; c0 = cyc;
        run = 1'b1; cyc_wait(n); run = 1'b0; cyc_wait(PERIOD + 4);
        exp_p = run_pulses(n);
        exp_count = sat_add(exp_count, exp_p);
        checks++; if (gen_total - g0 !== exp_p) begin errors++; $display("FAIL run_pulses n=%0d got %0d exp %0d", n, gen_total - g0, exp_p); end
        checks++; if (gen_times[g0 % 1024] - c0 !== PERIOD + 1) begin errors++; $display("FAIL run_first got %0d exp %0d", gen_times[g0 % 1024] - c0, PERIOD + 1); end
        for (int i = g0 + 1; i < gen_total; i++) begin
            checks++;
            if (gen_times[i % 1024] - gen_times[(i - 1) % 1024] !== PERIOD + 2) begin
                errors++; $display("FAIL run_spacing got %0d exp %0d", gen_times[i % 1024] - gen_times[(i - 1) % 1024], PERIOD + 2);
            end
        end
        checks++; if (gen_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL run_count got %0d exp %0d", gen_count, exp_count); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL run_stop_state got %0d exp 0", state_o); end
        g1 = gen_total; cyc_wait(12);
        checks++; if (gen_total !== g1) begin errors++; $display("FAIL run_stop_quiet got %0d exp %0d", gen_total, g1); end
    endtask

    task automatic test_priority();
        int l0, g0;
        toggle_en = 1'b1;
        l0 = load_total; g0 = gen_total;
        load_req = 1'b1; step_req = 1'b1; cyc_wait(2);
        load_req = 1'b0; step_req = 1'b0; cyc_wait(3);
        exp_count = 0;
        checks++; if (load_total - l0 !== 1) begin errors++; $display("FAIL prio_load got %0d exp 1", load_total - l0); end
        checks++; if (gen_total - g0 !== 0) begin errors++; $display("FAIL prio_no_gen got %0d exp 0", gen_total - g0); end
        // Load edge arriving during SETTLE
        step_req = 1'b1; cyc_wait(2);
        checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL prio_settle got %0d exp 4", state_o); end
        load_req = 1'b1; cyc_wait(1);
        checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL prio_settle_load got %0d exp 1", state_o); end
        checks++; if (load_en !== 1'b1) begin errors++; $display("FAIL prio_load_en got %b exp 1", load_en); end
        cyc_wait(1);
        checks++; if (gen_count !== 4'd0) begin errors++; $display("FAIL prio_count got %0d exp 0", gen_count); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL prio_idle got %0d exp 0", state_o); end
        load_req = 1'b0; step_req = 1'b0; cyc_wait(2);
    endtask

    task automatic test_still();
        int g0, l0, exp_p, exp_s;
        toggle_en = 1'b0;
        pat = {32{8'hA5}};
        g0 = gen_total;
        run = 1'b1; cyc_wait(30);
`ifdef LIFE_STILL_DETECT_EN
        exp_p = 1;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL still_halted got %b exp 1", halted); end
        checks++; if (state_o !== 3'd5) begin errors++; $display("FAIL still_state got %0d exp 5", state_o); end
`else
        exp_p = run_pulses(30);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL still_halted_off got %b exp 0", halted); end
`endif
        checks++; if (gen_total - g0 !== exp_p) begin errors++; $display("FAIL still_pulses got %0d exp %0d", gen_total - g0, exp_p); end
        exp_count = sat_add(exp_count, exp_p);
        run = 1'b0; cyc_wait(8);
        // Step request: swallowed while halted, honoured otherwise
        g0 = gen_total;
        step_req = 1'b1; cyc_wait(2); step_req = 1'b0; cyc_wait(3);
`ifdef LIFE_STILL_DETECT_EN
        exp_s = 0;
`else
        exp_s = 1;
`endif
        checks++; if (gen_total - g0 !== exp_s) begin errors++; $display("FAIL still_step got %0d exp %0d", gen_total - g0, exp_s); end
        exp_count = sat_add(exp_count, exp_s);
        checks++; if (gen_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL still_count got %0d exp %0d", gen_count, exp_count); end
        l0 = load_total;
        load_req = 1'b1; cyc_wait(2); load_req = 1'b0; cyc_wait(3);
        exp_count = 0;
        checks++; if (load_total - l0 !== 1) begin errors++; $display("FAIL still_load got %0d exp 1", load_total - l0); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL still_unhalt got %b exp 0", halted); end
        checks++; if (gen_count !== 4'd0) begin errors++; $display("FAIL still_clear got %0d exp 0", gen_count); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL still_idle got %0d exp 0", state_o); end
    endtask

    task automatic test_saturation();
        int g0, h, l;
        toggle_en = 1'b1;
        g0 = gen_total;
        for (int k = 0; k < 20; k++) begin
            h = $urandom_range(1, 4);
            l = $urandom_range(2, 4);
            step_req = 1'b1; cyc_wait(h); step_req = 1'b0; cyc_wait(l);
            exp_count = sat_add(exp_count, 1);
            checks++;
            if (gen_count !== CNT_W'(exp_count)) begin
                errors++; $display("FAIL sat_count k=%0d got %0d exp %0d", k, gen_count, exp_count);
            end
        end
        checks++; if (gen_total - g0 !== 20) begin errors++; $display("FAIL sat_pulses got %0d exp 20", gen_total - g0); end
    endtask

    task automatic test_async_reset();
        int l0, g0;
        toggle_en = 1'b1;
        checks++; if (gen_count !== CNT_W'(exp_count)) begin errors++; $display("FAIL ar_pre_count got %0d exp %0d", gen_count, exp_count); end
        run = 1'b1; cyc_wait(3);
        checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL ar_in_run got %0d exp 2", state_o); end
        l0 = load_total; g0 = gen_total;
        load_req = 1'b1;
        #2 reset = 1'b0;
        #1;
        exp_count = 0;
        checks++; if (load_en !== 1'b0) begin errors++; $display("FAIL ar_load_en got %b exp 0", load_en); end
        checks++; if (gen_en !== 1'b0) begin errors++; $display("FAIL ar_gen_en got %b exp 0", gen_en); end
        checks++; if (gen_count !== 4'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", gen_count); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL ar_halted got %b exp 0", halted); end
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL ar_state got %0d exp 0", state_o); end
        run = 1'b0; cyc_wait(2);
        reset = 1'b1; cyc_wait(4);
        checks++; if (load_total - l0 !== 1) begin errors++; $display("FAIL ar_held_load got %0d exp 1", load_total - l0); end
        checks++; if (gen_total - g0 !== 0) begin errors++; $display("FAIL ar_no_gen got %0d exp 0", gen_total - g0); end
        load_req = 1'b0; cyc_wait(2);
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL ar_final_state got %0d exp 0", state_o); end
    endtask

    initial begin
        #2 reset = 1'b0;
        cyc_wait(3);
        test_reset();
        reset = 1'b1;
        cyc_wait(2);
        test_load();
        test_step();
        test_free_run(40);
        test_free_run($urandom_range(20, 60));
        test_priority();
        test_still();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
